// File: rtl/spi_frame_writer_if.sv
// Byte-stream input, memory-arbiter write port and display-side status of spi_frame_writer.
// master is the frame writer itself; slave is the surrounding SPI slave / arbiter / LED side.
interface spi_frame_writer_if #(
    parameter int unsigned ADDRESS_WIDTH = 14,
    parameter int unsigned DATA_WIDTH    = 16
);
    logic [7:0]               data_in;
    logic                     data_in_ready;
    logic                     cs_n;
    logic [ADDRESS_WIDTH-1:0] address_mem;
    logic [DATA_WIDTH-1:0]    data_out_mem;
    logic                     wr_mem;
    logic                     data_out_ready_mem;
    logic                     fifo_full_mem;
    logic                     frame_buffer_select;
    logic                     frame_done;
    logic                     overflow;

    modport master (
        input  data_in,
        input  data_in_ready,
        input  cs_n,
        input  fifo_full_mem,
        output address_mem,
        output data_out_mem,
        output wr_mem,
        output data_out_ready_mem,
        output frame_buffer_select,
        output frame_done,
        output overflow
    );

    modport slave (
        output data_in,
        output data_in_ready,
        output cs_n,
        output fifo_full_mem,
        input  address_mem,
        input  data_out_mem,
        input  wr_mem,
        input  data_out_ready_mem,
        input  frame_buffer_select,
        input  frame_done,
        input  overflow
    );
endinterface

// File: rtl/spi_frame_writer.sv
// Turns SPI command/pixel byte transactions into 16-bit back-buffer write requests and
// owns the double-buffer select shown by the LED matrix controller.
module spi_frame_writer #(
    parameter int unsigned ADDRESS_WIDTH = 14,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FRAME_WORDS   = 8192
) (
    input logic                clk,
    input logic                reset,
    spi_frame_writer_if.master bus
);
    localparam int unsigned INDEX_WIDTH = $clog2(FRAME_WORDS);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StPixHi,
        StPixLo,
        StSwapWait,
        StDiscard
    } state_t;

    state_t                   state_q;
    state_t                   state_byte;
    logic                     cs_meta_q;
    logic                     cs_sync_q;
    logic                     cs_prev_q;
    logic                     cs_rise;
    logic                     cs_fall;
    logic [INDEX_WIDTH-1:0]   index_q;
    logic                     index_full_q;
    logic [7:0]               high_byte_q;
    logic                     pend_valid_q;
    logic [ADDRESS_WIDTH-1:0] pend_addr_q;
    logic [DATA_WIDTH-1:0]    pend_data_q;
    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0]    word_data;
    logic                     word_done;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     strobe_q;
    logic                     fbs_q;
    logic                     done_q;
    logic                     overflow_q;

    always_comb begin
        cs_rise    = cs_sync_q & ~cs_prev_q;
        cs_fall    = ~cs_sync_q & cs_prev_q;
        word_done  = bus.data_in_ready && (state_q == StPixLo);
        word_data  = DATA_WIDTH'({high_byte_q, bus.data_in});
        word_addr  = (fbs_q ? '0 : ADDRESS_WIDTH'(FRAME_WORDS)) + ADDRESS_WIDTH'(index_q);
        // State reached by processing this cycle's byte, before any cs_n rise closes it.
        state_byte = state_q;
        if (bus.data_in_ready) begin
            case (state_q)
                StCmd: begin
                    if (bus.data_in == 8'h01)      state_byte = StPixHi;
                    else if (bus.data_in == 8'h02) state_byte = StSwapWait;
                    else                           state_byte = StDiscard;
                end
                StPixHi: state_byte = StPixLo;
                StPixLo: state_byte = StPixHi;
                default: state_byte = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Synchroniser resets low so a chip select already held low after reset
            // never looks like a fresh falling edge.
            cs_meta_q    <= 1'b0;
            cs_sync_q    <= 1'b0;
            cs_prev_q    <= 1'b0;
            state_q      <= StIdle;
            index_q      <= '0;
            index_full_q <= 1'b0;
            high_byte_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            strobe_q     <= 1'b0;
            fbs_q        <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cs_meta_q <= bus.cs_n;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;

            if (pend_valid_q && !bus.fifo_full_mem) begin
                strobe_q     <= 1'b1;
                addr_q       <= pend_addr_q;
                data_q       <= pend_data_q;
                pend_valid_q <= 1'b0;
            end

            if (bus.data_in_ready && state_q == StCmd && bus.data_in == 8'h01) begin
                index_q      <= '0;
                index_full_q <= 1'b0;
            end

            if (bus.data_in_ready && state_q == StPixHi) begin
                high_byte_q <= bus.data_in;
            end

            if (word_done) begin
                if (index_full_q) begin
                    overflow_q <= 1'b1;
                end else begin
                    if (!bus.fifo_full_mem && !pend_valid_q) begin
                        strobe_q <= 1'b1;
                        addr_q   <= word_addr;
                        data_q   <= word_data;
                    end else if (!(pend_valid_q && bus.fifo_full_mem)) begin
                        // Slot is empty or drains this cycle, so it can take the new word.
                        pend_valid_q <= 1'b1;
                        pend_addr_q  <= word_addr;
                        pend_data_q  <= word_data;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                    if (index_q == LAST_INDEX) index_full_q <= 1'b1;
                    else                       index_q      <= index_q + 1'b1;
                end
            end

            if (cs_rise) begin
                state_q <= StIdle;
                if (state_byte == StSwapWait) begin
                    fbs_q  <= ~fbs_q;
                    done_q <= 1'b1;
                end
            end else if (cs_fall && state_q == StIdle) begin
                state_q <= StCmd;
            end else begin
                state_q <= state_byte;
            end
        end
    end

    assign bus.address_mem         = addr_q;
    assign bus.data_out_mem        = data_q;
    assign bus.wr_mem              = strobe_q;
    assign bus.data_out_ready_mem  = strobe_q;
    assign bus.frame_buffer_select = fbs_q;
    assign bus.frame_done          = done_q;
    assign bus.overflow            = overflow_q;
endmodule

// File: tb/tb_spi_frame_writer.sv
// Bench for spi_frame_writer: vector table, hand-written corner sequences and a randomized
// phase scored against a transaction-level model of the frame writer.
module tb_spi_frame_writer;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 8192;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;
    typedef struct {
        logic [7:0]    b[5];
        int            n;
        int            reqs;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          fbs;
        int            done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    logic prev_full = 1'b0;
    logic model_fbs = 1'b0;
    req_t got[$];
    req_t exp_q[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    spi_frame_writer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spi_frame_writer #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .FRAME_WORDS  (FW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request collector plus protocol rules that must hold on every cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_full <= 1'b0;
        end else begin
            if (bus.data_out_ready_mem || bus.wr_mem)
                check("wr_qualifier", {30'd0, bus.wr_mem, bus.data_out_ready_mem}, 32'd3);
            if (bus.data_out_ready_mem) begin
                check("backpressure", {31'd0, prev_full}, 32'd0);
                got.push_back({bus.address_mem, bus.data_out_mem});
            end
            if (bus.frame_done) done_count++;
            prev_full <= bus.fifo_full_mem;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit full_pulse);
        bus.data_in       = b;
        bus.data_in_ready = 1'b1;
        if (full_pulse) bus.fifo_full_mem = 1'b1;
        tick();
        bus.data_in_ready = 1'b0;
        if (full_pulse) bus.fifo_full_mem = 1'b0;
        repeat (1 + gap) tick();
    endtask

    task automatic cs_low();
        bus.cs_n = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_high();
        bus.cs_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic run_txn(input bq_t q, input bit rnd);
        cs_low();
        foreach (q[i])
            send_byte(q[i], rnd ? int'($urandom_range(0, 3)) : 0,
                      rnd ? ($urandom_range(0, 2) == 0) : 1'b0);
        cs_high();
    endtask

    initial begin
        bq_t q;
        int  bad;

        vecs[0] = '{b: '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD}, n: 5, reqs: 2,
                    a0: 14'h2000, d0: 16'h1234, a1: 14'h2001, d1: 16'hABCD, fbs: 1'b0, done: 0};
        vecs[1] = '{b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, n: 1, reqs: 0,
                    a0: 14'h0, d0: 16'h0, a1: 14'h0, d1: 16'h0, fbs: 1'b1, done: 1};
        vecs[2] = '{b: '{8'h01, 8'h55, 8'h66, 8'h00, 8'h00}, n: 3, reqs: 1,
                    a0: 14'h0000, d0: 16'h5566, a1: 14'h0, d1: 16'h0, fbs: 1'b1, done: 0};
        vecs[3] = '{b: '{8'h7F, 8'h01, 8'h02, 8'h03, 8'h04}, n: 5, reqs: 0,
                    a0: 14'h0, d0: 16'h0, a1: 14'h0, d1: 16'h0, fbs: 1'b1, done: 0};
        vecs[4] = '{b: '{8'h01, 8'h11, 8'h22, 8'h33, 8'h00}, n: 4, reqs: 1,
                    a0: 14'h0000, d0: 16'h1122, a1: 14'h0, d1: 16'h0, fbs: 1'b1, done: 0};

        reset             = 1'b1;
        bus.cs_n          = 1'b1;
        bus.data_in       = 8'h00;
        bus.data_in_ready = 1'b0;
        bus.fifo_full_mem = 1'b0;
        repeat (3) tick();
        check("reset_addr", 32'(bus.address_mem), 32'h0);
        check("reset_data", 32'(bus.data_out_mem), 32'h0);
        check("reset_strobe", {30'd0, bus.wr_mem, bus.data_out_ready_mem}, 32'd0);
        check("reset_flags", {29'd0, bus.frame_done, bus.overflow, bus.frame_buffer_select}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 5; i++) begin
            q = {};
            for (int k = 0; k < vecs[i].n; k++) q.push_back(vecs[i].b[k]);
            got.delete();
            done_count = 0;
            run_txn(q, 1'b0);
            check($sformatf("vec%0d_reqs", i), 32'(got.size()), 32'(vecs[i].reqs));
            if (vecs[i].reqs > 0 && got.size() > 0)
                check($sformatf("vec%0d_req0", i), 32'(got[0]), 32'({vecs[i].a0, vecs[i].d0}));
            if (vecs[i].reqs > 1 && got.size() > 1)
                check($sformatf("vec%0d_req1", i), 32'(got[1]), 32'({vecs[i].a1, vecs[i].d1}));
            check($sformatf("vec%0d_fbs", i), {31'd0, bus.frame_buffer_select}, {31'd0, vecs[i].fbs});
            check($sformatf("vec%0d_done", i), 32'(done_count), 32'(vecs[i].done));
            check($sformatf("vec%0d_ovf", i), {31'd0, bus.overflow}, 32'd0);
        end

        // Swap latency: select toggles on the third edge after the pin rises.
        got.delete();
        cs_low();
        send_byte(8'h02, 0, 1'b0);
        bus.cs_n = 1'b1;
        tick();
        check("swap_lat1", {31'd0, bus.frame_buffer_select}, 32'd1);
        tick();
        check("swap_lat2", {31'd0, bus.frame_buffer_select}, 32'd1);
        tick();
        check("swap_lat3", {31'd0, bus.frame_buffer_select}, 32'd0);
        check("swap_done_hi", {31'd0, bus.frame_done}, 32'd1);
        tick();
        check("swap_done_lo", {31'd0, bus.frame_done}, 32'd0);
        repeat (3) tick();

        // Word latency: strobe with registered address/data in the cycle after the low byte.
        got.delete();
        cs_low();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hC3, 0, 1'b0);
        bus.data_in       = 8'h5A;
        bus.data_in_ready = 1'b1;
        tick();
        bus.data_in_ready = 1'b0;
        check("lat_strobe", {30'd0, bus.wr_mem, bus.data_out_ready_mem}, 32'd3);
        check("lat_word", 32'({bus.address_mem, bus.data_out_mem}), 32'({14'h2000, 16'hC35A}));
        tick();
        check("lat_strobe_off", {31'd0, bus.data_out_ready_mem}, 32'd0);
        cs_high();
        check("lat_count", 32'(got.size()), 32'd1);

        // Back-pressure: first word pended, second dropped, only the first is issued.
        got.delete();
        cs_low();
        send_byte(8'h01, 0, 1'b0);
        bus.fifo_full_mem = 1'b1;
        send_byte(8'hA1, 0, 1'b0);
        send_byte(8'hB2, 0, 1'b0);
        send_byte(8'hC3, 0, 1'b0);
        send_byte(8'hD4, 0, 1'b0);
        repeat (3) tick();
        check("bp_held", 32'(got.size()), 32'd0);
        check("bp_ovf", {31'd0, bus.overflow}, 32'd1);
        bus.fifo_full_mem = 1'b0;
        repeat (4) tick();
        check("bp_release_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("bp_release_word", 32'(got[0]), 32'({14'h2000, 16'hA1B2}));
        cs_high();
        check("bp_final_count", 32'(got.size()), 32'd1);

        // Reset between high and low byte; cs_n stays low through and after reset.
        got.delete();
        cs_low();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h77, 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("rst_addr", 32'(bus.address_mem), 32'h0);
        check("rst_data", 32'(bus.data_out_mem), 32'h0);
        check("rst_flags", {28'd0, bus.data_out_ready_mem, bus.frame_done, bus.overflow,
                            bus.frame_buffer_select}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send_byte(8'h88, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h99, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        repeat (4) tick();
        check("rst_no_request", 32'(got.size()), 32'd0);
        cs_high();
        model_fbs = 1'b0;

        // Boundary: 8193 words into one frame; the last one overflows.
        got.delete();
        cs_low();
        send_byte(8'h01, 0, 1'b0);
        for (int w = 0; w < int'(FW); w++) begin
            send_byte(8'(w >> 8), 0, 1'b0);
            send_byte(8'(w), 0, 1'b0);
        end
        check("bnd_ovf_before", {31'd0, bus.overflow}, 32'd0);
        send_byte(8'hEE, 0, 1'b0);
        send_byte(8'hFF, 0, 1'b0);
        repeat (3) tick();
        check("bnd_ovf_after", {31'd0, bus.overflow}, 32'd1);
        check("bnd_count", 32'(got.size()), 32'(FW));
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== {AW'(int'(FW) + i), DW'(i)}) bad++;
        check("bnd_stream", 32'(bad), 32'd0);
        if (got.size() > 0) check("bnd_last_addr", 32'(got[got.size()-1].addr), 32'h3FFF);
        cs_high();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        model_fbs = 1'b0;

        // Random transactions against the transaction-level model.
        for (int t = 0; t < 30; t++) begin
            int          r;
            int          np;
            int          exp_done;
            int          base;
            logic [7:0]  cmd;
            r  = int'($urandom_range(0, 9));
            if (r < 5)      cmd = 8'h01;
            else if (r < 7) cmd = 8'h02;
            else            cmd = 8'($urandom_range(3, 255));
            np = int'($urandom_range(0, 9));
            q  = {};
            q.push_back(cmd);
            repeat (np) q.push_back(8'($urandom));

            exp_q.delete();
            exp_done = 0;
            base = model_fbs ? 0 : int'(FW);
            if (cmd == 8'h01) begin
                for (int k = 0; k + 1 < np; k += 2)
                    exp_q.push_back({AW'(base + k / 2), q[1 + k], q[2 + k]});
            end else if (cmd == 8'h02) begin
                model_fbs = ~model_fbs;
                exp_done  = 1;
            end

            got.delete();
            done_count = 0;
            run_txn(q, 1'b1);
            check($sformatf("rnd%0d_count", t), 32'(got.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < got.size(); k++)
                check($sformatf("rnd%0d_req%0d", t, k), 32'(got[k]), 32'(exp_q[k]));
            check($sformatf("rnd%0d_fbs", t), {31'd0, bus.frame_buffer_select}, {31'd0, model_fbs});
            check($sformatf("rnd%0d_done", t), 32'(done_count), 32'(exp_done));
            check($sformatf("rnd%0d_ovf", t), {31'd0, bus.overflow}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
